// File: rtl/i2s_rx_mc.sv
// i2s_rx_mc: I2S / left-justified receiver (bus master) with an FWFT sample FIFO.
// Generates sck/ws from clk, deserialises MSB-first slots from sdi and queues
// {channel tag, right-aligned sample} words with threshold/overrun flags.
// Build option: I2S_RX_MC_SIGN_EXT_EN sign-extends samples narrower than DW.
module i2s_rx_mc #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    sck_prescaler,
  input  logic [4:0]    sample_size,
  input  logic [1:0]    channels,
  input  logic          lj_mode,
  output logic          sck,
  output logic          ws,
  input  logic          sdi,
  input  logic          fifo_rd,
  output logic [DW:0]   fifo_rdata,
  output logic [AW:0]   fifo_level,
  input  logic [AW:0]   fifo_threshold,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          fifo_level_above,
  output logic          overrun,
  input  logic          overrun_clr
);

`ifdef I2S_RX_MC_SIGN_EXT_EN
  localparam bit SIGN_EXT = 1'b1;
`else
  localparam bit SIGN_EXT = 1'b0;
`endif

  localparam int DEPTH = 1 << AW;

  // clock generator / slot tracking state
  logic [7:0] cnt_q;
  logic       sck_q, ws_q, started_q;
  logic [5:0] rcnt_q;      // rising edges issued in the current ws slot
  logic       rise_q;      // one clk wide, aligned with the cycle sck goes high
  logic [4:0] rb_q;        // slot bit index of that rising edge
  logic       rch_q;       // channel that bit belongs to
  logic       rv_q;        // bit belongs to a real slot (not the pre-start wrap)
  logic [4:0] rb_d;
  logic       rch_d, rv_d;

  // capture state
  logic [31:0]   sr_q, sr_d;
  logic          push_q, last;
  logic [DW:0]   pdata_q;
  logic [DW-1:0] smp;
  logic          msb;
  logic [5:0]    n_eff;

  // fifo state
  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   lvl_q;
  logic          ovr_q;
  logic          do_push, do_pop;

  wire tick = (cnt_q == 8'd0);

  // effective sample size: 0 means 32, clamped to DW
  always_comb begin
    n_eff = (sample_size == 5'd0) ? 6'd32 : {1'b0, sample_size};
    if (n_eff > 6'(DW)) n_eff = 6'(DW);
  end

  // bit index of the next rising edge; in I2S the first edge of a slot is the
  // LSB position (31) of the previous slot
  always_comb begin
    rb_d  = rcnt_q[4:0];
    rch_d = ws_q;
    rv_d  = 1'b1;
    if (!lj_mode) begin
      if (rcnt_q == 6'd0) begin
        rb_d  = 5'd31;
        rch_d = ~ws_q;
        rv_d  = started_q;
      end else begin
        rb_d  = rcnt_q[4:0] - 5'd1;
      end
    end
  end

  // prescaler, sck/ws generation and rising-edge bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0; sck_q <= 1'b0; ws_q <= 1'b0; started_q <= 1'b0;
      rcnt_q <= '0; rise_q <= 1'b0; rb_q <= '0; rch_q <= 1'b0; rv_q <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0; sck_q <= 1'b0; ws_q <= 1'b0; started_q <= 1'b0;
      rcnt_q <= '0; rise_q <= 1'b0; rb_q <= '0; rch_q <= 1'b0; rv_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      if (tick) begin
        cnt_q <= sck_prescaler;
        sck_q <= ~sck_q;
        if (!sck_q) begin
          rcnt_q <= rcnt_q + 6'd1;
          rise_q <= 1'b1;
          rb_q   <= rb_d;
          rch_q  <= rch_d;
          rv_q   <= rv_d;
        end else if (rcnt_q == 6'd32) begin
          ws_q      <= ~ws_q;
          rcnt_q    <= '0;
          started_q <= 1'b1;
        end
      end else begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  // shift in captured bits and format the finished word
  always_comb begin
    sr_d = sr_q;
    last = 1'b0;
    smp  = '0;
    if (rise_q && rv_q && ({1'b0, rb_q} < n_eff)) begin
      sr_d = (rb_q == 5'd0) ? {31'd0, sdi} : {sr_q[30:0], sdi};
      last = ({1'b0, rb_q} == (n_eff - 6'd1)) && channels[rch_q];
    end
    msb = sr_d[n_eff[4:0] - 5'd1];
    for (int i = 0; i < DW; i++)
      smp[i] = (i < int'(n_eff)) ? sr_d[i] : (SIGN_EXT & msb);
  end

  // sample register and push strobe (push lands one clk after the last bit)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0; push_q <= 1'b0; pdata_q <= '0;
    end else if (!en) begin
      sr_q <= '0; push_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      push_q <= last;
      if (last) pdata_q <= {rch_q, smp};
    end
  end

  assign fifo_empty       = (lvl_q == '0);
  assign fifo_full        = (lvl_q == (AW+1)'(DEPTH));
  assign do_pop           = fifo_rd && !fifo_empty;
  assign do_push          = push_q && (!fifo_full || do_pop);
  assign fifo_level       = lvl_q;
  assign fifo_level_above = (lvl_q > fifo_threshold);
  assign fifo_rdata       = fifo_empty ? '0 : mem[rp_q];
  assign overrun          = ovr_q;
  assign sck              = sck_q;
  assign ws               = ws_q;

  // fifo storage, contents unreset (level/pointers define validity)
  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q] <= pdata_q;
  end

  // fifo pointers, level and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0; rp_q <= '0; lvl_q <= '0; ovr_q <= 1'b0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
      if (push_q && fifo_full && !do_pop) ovr_q <= 1'b1;
      else if (overrun_clr)               ovr_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_mc.sv
// tb_i2s_rx_mc: microphone model drives sdi from the DUT's sck/ws, queues the
// expected FIFO words as each slot's last bit is sent; pops are compared.
module tb_i2s_rx_mc;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, en, lj_mode, sdi, fifo_rd, overrun_clr;
  logic [7:0]    presc;
  logic [4:0]    ss;
  logic [1:0]    chans;
  logic [AW:0]   thr;
  logic          sck, ws, fifo_empty, fifo_full, fifo_level_above, overrun;
  logic [DW:0]   fifo_rdata;
  logic [AW:0]   fifo_level;

  logic [31:0]   val_l, val_r;
  logic [DW:0]   sb[$];
  int            n_cmp = 0, n_bad = 0;
  int            kk = 0, last_cnt = 0;
  logic          sck_p = 1'b0, ws_p = 1'b0;

  i2s_rx_mc #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .sck_prescaler(presc), .sample_size(ss),
    .channels(chans), .lj_mode(lj_mode), .sck(sck), .ws(ws), .sdi(sdi),
    .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata), .fifo_level(fifo_level),
    .fifo_threshold(thr), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_level_above(fifo_level_above), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int neff();
    int n;
    n = (ss == 5'd0) ? 32 : int'(ss);
    if (n > DW) n = DW;
    return n;
  endfunction

  function automatic logic [DW:0] exp_w(logic ch, logic [31:0] v, int n);
    logic [31:0] m, d;
    m = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    d = v & m;
`ifdef I2S_RX_MC_SIGN_EXT_EN
    if (v[n-1]) d = d | ~m;
`endif
    return {ch, d[DW-1:0]};
  endfunction

  function automatic logic mic_bit(int k, logic w);
    logic [31:0] mw;
    int b;
    mw = (w ? val_r : val_l) << (32 - neff());
    if (lj_mode) b = k;
    else if (k == 0) return 1'b0;
    else b = k - 1;
    if (b > 31) return 1'b0;
    return mw[31-b];
  endfunction

  // microphone: change sdi while sck is low, count rises per ws slot
  always @(negedge clk) begin
    if (rst || !en) begin
      kk  = 0;
      sdi = 1'b0;
    end else begin
      if (sck && !sck_p) begin
        int  b;
        logic v;
        b = lj_mode ? kk : kk - 1;
        v = lj_mode || (kk != 0);
        if (v && b == neff() - 1 && chans[ws]) begin
          sb.push_back(exp_w(ws, ws ? val_r : val_l, neff()));
          last_cnt++;
        end
        kk++;
      end
      if (ws != ws_p) kk = 0;
      if (!sck) sdi = mic_bit(kk, ws);
    end
    sck_p = sck;
    ws_p  = ws;
  end

  task automatic wait_level(int lvl, int budget, string tag);
    int i = 0;
    while (int'(fifo_level) < lvl && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 64'(int'(fifo_level) >= lvl), 64'd1);
  endtask

  task automatic pop_chk(string tag);
    logic [DW:0] e;
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    chk(tag, 64'(fifo_rdata), 64'(e));
    fifo_rd = 1'b1;
    @(negedge clk);
    fifo_rd = 1'b0;
  endtask

  task automatic drain(string tag);
    int g = 0;
    while (fifo_level != 0 && g < 40) begin
      if (fifo_level == 6) chk({tag, "_above6"}, 64'(fifo_level_above), 64'd1);
      if (fifo_level == 5) chk({tag, "_above5"}, 64'(fifo_level_above), 64'd0);
      pop_chk(tag);
      g++;
    end
    chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int c, lc;
    rst = 1'b1; en = 1'b0; lj_mode = 1'b0; fifo_rd = 1'b0; overrun_clr = 1'b0;
    presc = 8'd4; ss = 5'd18; chans = 2'b01; thr = 5'd5;
    val_l = 32'h2A5A5; val_r = 32'h11111;
    repeat (3) @(negedge clk);
    chk("rst_sck", 64'(sck), 64'd0);
    chk("rst_ws", 64'(ws), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_empty", 64'(fifo_empty), 64'd1);
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk("rst_above", 64'(fifo_level_above), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    chk("rst_rdata", 64'(fifo_rdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // I2S, 18-bit left channel only
    en = 1'b1;
    wait_level(1, 3000, "t1_wait");
    en = 1'b0;
`ifdef I2S_RX_MC_SIGN_EXT_EN
    chk("t1_const", 64'(fifo_rdata), 64'h0_FFFE_A5A5);
`else
    chk("t1_const", 64'(fifo_rdata), 64'h0_0002_A5A5);
`endif
    drain("t1");

    // LJ, 24-bit stereo, ws period
    lj_mode = 1'b1; chans = 2'b11; ss = 5'd24;
    val_l = 32'h123456; val_r = 32'h654321;
    en = 1'b1;
    c = 0;
    while (!ws && c < 2000) begin @(negedge clk); c++; end
    c = 0;
    while (ws && c < 2000) begin @(negedge clk); c++; end
    while (!ws && c < 2000) begin @(negedge clk); c++; end
    chk("t2_ws_period", 64'(c), 64'd640);
    wait_level(4, 3000, "t2_wait");
    en = 1'b0;
    chk("t2_tag0", 64'(fifo_rdata[DW]), 64'd0);
    drain("t2");

    // fill to overrun, clear it, push+pop while full
    presc = 8'd0; ss = 5'd8; val_l = 32'hA5; val_r = 32'h3C;
    en = 1'b1;
    c = 0;
    while (!overrun && c < 3000) begin @(negedge clk); c++; end
    chk("t3_ovr", 64'(overrun), 64'd1);
    chk("t3_level", 64'(fifo_level), 64'd16);
    chk("t3_full", 64'(fifo_full), 64'd1);
    chk("t3_sb17", 64'(sb.size()), 64'd17);
    if (sb.size() != 0) void'(sb.pop_back());
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("t3_ovr_clr", 64'(overrun), 64'd0);
    lc = last_cnt; c = 0;
    while (last_cnt == lc && c < 500) begin @(posedge clk); c++; end
    #1;
    begin
      logic [DW:0] e;
      e = (sb.size() != 0) ? sb.pop_front() : 'x;
      chk("t3_pp_data", 64'(fifo_rdata), 64'(e));
    end
    fifo_rd = 1'b1;
    @(posedge clk);
    #1 fifo_rd = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("t3_pp_level", 64'(fifo_level), 64'd16);
    chk("t3_pp_ovr", 64'(overrun), 64'd0);
    drain("t3");
    chk("t3_empty", 64'(fifo_empty), 64'd1);
    fifo_rd = 1'b1;
    @(negedge clk);
    fifo_rd = 1'b0;
    chk("t3_pop_empty_lvl", 64'(fifo_level), 64'd0);
    chk("t3_pop_empty_rd", 64'(fifo_rdata), 64'd0);

    // enable dropped mid-slot
    presc = 8'd2; chans = 2'b01; ss = 5'd24; val_l = 32'hABCDEF;
    en = 1'b1;
    c = 0;
    while (!(kk >= 10 && !ws) && c < 2000) begin @(negedge clk); c++; end
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_sck_off", 64'(sck), 64'd0);
    chk("t4_ws_off", 64'(ws), 64'd0);
    chk("t4_level", 64'(fifo_level), 64'd0);
    en = 1'b1;
    wait_level(1, 3000, "t4_wait");
    en = 1'b0;
    chk("t4_tag", 64'(fifo_rdata[DW]), 64'd0);
    drain("t4");

    // asynchronous reset with words queued
    presc = 8'd0; chans = 2'b11; ss = 5'd16;
    en = 1'b1;
    wait_level(3, 3000, "t5_wait");
    c = 0;
    while (!sck && c < 10) begin @(negedge clk); c++; end
    #1 rst = 1'b1;
    #1;
    chk("t5_level", 64'(fifo_level), 64'd0);
    chk("t5_empty", 64'(fifo_empty), 64'd1);
    chk("t5_sck", 64'(sck), 64'd0);
    chk("t5_rdata", 64'(fifo_rdata), 64'd0);
    en = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
